vproc_mem_bridge: RTL and testbench

- Request-buffering bridge between the vproc_top data/instruction memory port and the mmu request port.
- Queues every vproc_top request in a FIFO (vproc_top has no grant signal) and issues requests to the mmu one at a time.
- Applies a fixed address offset, holds address, we, be and wdata stable until the mmu responds, and returns responses in order.
- Converts an mmu hang into an error response via a timeout.

---
 rtl/vproc_pkg.sv | 25 ++
 rtl/vproc_bridge_fifo.sv | 71 +++++++
 rtl/vproc_mem_bridge.sv | 161 ++++++++++++++++
 tb/tb_vproc_mem_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// -----------------------------------------------------------------------------
// vproc_pkg
// Shared types for the vproc memory path.
//   VPROC_MEM_W    : memory data width used by the request record
//   mem_req_t      : one buffered memory request {addr, we, be, wdata}
//   bridge_state_e : request-issue state of vproc_mem_bridge
// -----------------------------------------------------------------------------
package vproc_pkg;

    localparam int unsigned VPROC_MEM_W = 32;

    typedef struct packed {
        logic [31:0]                addr;
        logic                       we;
        logic [VPROC_MEM_W/8-1:0]   be;
        logic [VPROC_MEM_W-1:0]     wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/vproc_bridge_fifo.sv
// -----------------------------------------------------------------------------
// vproc_bridge_fifo
// Synchronous FIFO holding pending memory requests. A written entry becomes
// visible at o_data only from the cycle after the push (no fall-through).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   i_push    : write i_data; ignored when full unless popping in the same cycle
//   i_data    : entry to write
//   i_pop     : remove the head entry; ignored when empty
//   o_data    : head entry (valid when !o_empty)
//   o_full    : DEPTH entries stored
//   o_empty   : no entries stored
//   o_count   : number of stored entries
// -----------------------------------------------------------------------------
module vproc_bridge_fifo
    import vproc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = mem_req_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/vproc_mem_bridge.sv
// -----------------------------------------------------------------------------
// vproc_mem_bridge
// Buffers vproc_top memory requests (which cannot be back-pressured) and feeds
// them to the mmu one at a time, offsetting the address and holding the
// request fields stable until the mmu answers. A stalled mmu is turned into an
// error response after TIMEOUT wait cycles (0 = wait forever).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   up_req_i ..     : request from vproc_top (addr, we, be, wdata)
//   up_rvalid_o     : one-cycle response pulse, with up_err_o / up_rdata_o
//   dn_req_o        : one-cycle request pulse to the mmu
//   dn_addr_o ..    : request fields to the mmu, held until its response
//   dn_rvalid_i ..  : mmu response (valid, err, rdata)
//   busy_o          : requests queued or in flight
//   overflow_o      : sticky, a request was dropped on a full FIFO
// -----------------------------------------------------------------------------
module vproc_mem_bridge
    import vproc_pkg::*;
#(
    parameter int unsigned MEM_W       = VPROC_MEM_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] ADDR_OFFSET = 32'h0000_2000,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_req_i,
    input  logic [31:0]          up_addr_i,
    input  logic                 up_we_i,
    input  logic [MEM_W/8-1:0]   up_be_i,
    input  logic [MEM_W-1:0]     up_wdata_i,
    output logic                 up_rvalid_o,
    output logic                 up_err_o,
    output logic [MEM_W-1:0]     up_rdata_o,
    output logic                 dn_req_o,
    output logic [31:0]          dn_addr_o,
    output logic                 dn_we_o,
    output logic [MEM_W/8-1:0]   dn_be_o,
    output logic [MEM_W-1:0]     dn_wdata_o,
    input  logic                 dn_rvalid_i,
    input  logic                 dn_err_i,
    input  logic [MEM_W-1:0]     dn_rdata_i,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    mem_req_t                    w_push_req;
    mem_req_t                    w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_pop;

    bridge_state_e               r_state;
    logic [TIMER_W-1:0]          r_timer;
    logic                        r_dn_req;
    logic [31:0]                 r_dn_addr;
    logic                        r_dn_we;
    logic [MEM_W/8-1:0]          r_dn_be;
    logic [MEM_W-1:0]            r_dn_wdata;
    logic                        r_up_rvalid;
    logic                        r_up_err;
    logic [MEM_W-1:0]            r_up_rdata;
    logic                        r_overflow;

    always_comb begin
        w_push_req       = '0;
        w_push_req.addr  = up_addr_i;
        w_push_req.we    = up_we_i;
        w_push_req.be    = up_be_i;
        w_push_req.wdata = up_wdata_i;
    end

    // The head is taken only while idle, so at most one request is downstream.
    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    vproc_bridge_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (mem_req_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (up_req_i),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_dn_req    <= 1'b0;
            r_dn_addr   <= '0;
            r_dn_we     <= 1'b0;
            r_dn_be     <= '0;
            r_dn_wdata  <= '0;
            r_up_rvalid <= 1'b0;
            r_up_err    <= 1'b0;
            r_up_rdata  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_dn_req    <= 1'b0;
            r_up_rvalid <= 1'b0;

            if (up_req_i && w_full && !w_pop) r_overflow <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_dn_addr  <= w_head.addr + ADDR_OFFSET;
                        r_dn_we    <= w_head.we;
                        r_dn_be    <= w_head.be;
                        r_dn_wdata <= w_head.wdata;
                        r_dn_req   <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // A real response takes priority over a coinciding timeout.
                    if (dn_rvalid_i) begin
                        r_up_rdata  <= dn_rdata_i;
                        r_up_err    <= dn_err_i;
                        r_up_rvalid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_timer == TIMER_LAST)) begin
                        r_up_rdata  <= '0;
                        r_up_err    <= 1'b1;
                        r_up_rvalid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dn_req_o    = r_dn_req;
    assign dn_addr_o   = r_dn_addr;
    assign dn_we_o     = r_dn_we;
    assign dn_be_o     = r_dn_be;
    assign dn_wdata_o  = r_dn_wdata;
    assign up_rvalid_o = r_up_rvalid;
    assign up_err_o    = r_up_err;
    assign up_rdata_o  = r_up_rdata;
    assign overflow_o  = r_overflow;
    assign busy_o      = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_vproc_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_vproc_mem_bridge
// Scoreboard bench for vproc_mem_bridge. Issued requests push the expected
// downstream request and the expected upstream response into queues; an mmu
// model answers downstream requests, and a monitor pops and compares every
// up_rvalid_o pulse. The mmu answers with data derived from the address, and
// never answers addresses whose top nibble is 0xF (forcing a timeout).
// -----------------------------------------------------------------------------
module tb_vproc_mem_bridge;

    localparam int unsigned MEM_W = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 8;
    localparam logic [31:0] OFF   = 32'h0000_2000;

    logic        clk;
    logic        rst;
    logic        up_req_i;
    logic [31:0] up_addr_i;
    logic        up_we_i;
    logic [3:0]  up_be_i;
    logic [31:0] up_wdata_i;
    logic        up_rvalid_o;
    logic        up_err_o;
    logic [31:0] up_rdata_o;
    logic        dn_req_o;
    logic [31:0] dn_addr_o;
    logic        dn_we_o;
    logic [3:0]  dn_be_o;
    logic [31:0] dn_wdata_o;
    logic        dn_rvalid_i;
    logic        dn_err_i;
    logic [31:0] dn_rdata_i;
    logic        busy_o;
    logic        overflow_o;

    logic        mmu_rv;
    logic        stray_rv;

    assign dn_rvalid_i = mmu_rv | stray_rv;

    vproc_mem_bridge #(
        .MEM_W       (MEM_W),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_OFFSET (OFF),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up_req_i    (up_req_i),
        .up_addr_i   (up_addr_i),
        .up_we_i     (up_we_i),
        .up_be_i     (up_be_i),
        .up_wdata_i  (up_wdata_i),
        .up_rvalid_o (up_rvalid_o),
        .up_err_o    (up_err_o),
        .up_rdata_o  (up_rdata_o),
        .dn_req_o    (dn_req_o),
        .dn_addr_o   (dn_addr_o),
        .dn_we_o     (dn_we_o),
        .dn_be_o     (dn_be_o),
        .dn_wdata_o  (dn_wdata_o),
        .dn_rvalid_i (dn_rvalid_i),
        .dn_err_i    (dn_err_i),
        .dn_rdata_i  (dn_rdata_i),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dn_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } up_exp_t;

    dn_exp_t exp_dn[$];
    up_exp_t exp_up[$];

    int vectors     = 0;
    int miscompares = 0;
    int issued      = 0;
    int resp_cnt    = 0;
    int fixed_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    // mmu behaviour, as seen on the downstream address.
    function automatic logic [31:0] mmu_data(input logic [31:0] a);
        if (a == 32'h0000_2100)  return 32'hDEAD_BEEF;
        if (a[31:16] == 16'h0)   return a;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic mmu_errf(input logic [31:0] a);
        return (a[31:28] == 4'hE);
    endfunction

    function automatic logic mmu_silent(input logic [31:0] a);
        return (a[31:28] == 4'hF);
    endfunction

    function automatic up_exp_t model(input logic [31:0] up_addr);
        up_exp_t     r;
        logic [31:0] dn;
        dn = up_addr + OFF;
        if (mmu_silent(dn)) begin
            r.err   = 1'b1;
            r.rdata = 32'h0;
        end else begin
            r.err   = mmu_errf(dn);
            r.rdata = mmu_data(dn);
        end
        return r;
    endfunction

    // Called aligned to posedge+#1; drives up_req_i for exactly one cycle.
    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input bit drop, input bit want_resp);
        dn_exp_t d;
        up_req_i   = 1'b1;
        up_addr_i  = a;
        up_we_i    = we;
        up_be_i    = be;
        up_wdata_i = wd;
        if (!drop) begin
            d.addr  = a + OFF;
            d.we    = we;
            d.be    = be;
            d.wdata = wd;
            exp_dn.push_back(d);
            if (want_resp) begin
                exp_up.push_back(model(a));
                issued++;
            end
        end
        @(posedge clk); #1;
        up_req_i = 1'b0;
    endtask

    task automatic wait_resp(input int budget);
        int n;
        n = 0;
        while (resp_cnt < issued && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (resp_cnt < issued) fail("resp_timeout");
    endtask

    // mmu model: checks each downstream request and that it stays stable.
    initial begin
        dn_exp_t e;
        int      d;
        mmu_rv     = 1'b0;
        dn_err_i   = 1'b0;
        dn_rdata_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst && dn_req_o) begin
                if (exp_dn.size() == 0) begin
                    fail("dn_req_unexpected");
                end else begin
                    e = exp_dn.pop_front();
                    check("dn_addr",  64'(dn_addr_o),  64'(e.addr));
                    check("dn_we",    64'(dn_we_o),    64'(e.we));
                    check("dn_be",    64'(dn_be_o),    64'(e.be));
                    check("dn_wdata", 64'(dn_wdata_o), 64'(e.wdata));
                    if (!mmu_silent(e.addr)) begin
                        d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(7, 1));
                        for (int i = 0; i < d; i++) begin
                            @(posedge clk); #1;
                            check("dn_hold_addr",  64'(dn_addr_o),  64'(e.addr));
                            check("dn_hold_wdata", 64'(dn_wdata_o), 64'(e.wdata));
                            check("dn_hold_we_be", 64'({dn_we_o, dn_be_o}), 64'({e.we, e.be}));
                            check("dn_req_pulse",  64'(dn_req_o),   64'(0));
                        end
                        mmu_rv     = 1'b1;
                        dn_err_i   = mmu_errf(e.addr);
                        dn_rdata_i = mmu_data(e.addr);
                        @(posedge clk); #1;
                        mmu_rv     = 1'b0;
                        dn_rdata_i = $urandom();
                        check("dn_req_spacing", 64'(dn_req_o), 64'(0));
                    end
                end
            end
        end
    end

    // Response monitor.
    initial begin
        up_exp_t e;
        forever begin
            @(negedge clk);
            if (up_rvalid_o) begin
                if (exp_up.size() == 0) begin
                    fail("up_rvalid_unexpected");
                end else begin
                    e = exp_up.pop_front();
                    check("up_err",   64'(up_err_o),   64'(e.err));
                    check("up_rdata", 64'(up_rdata_o), 64'(e.rdata));
                    resp_cnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          n;

        rst        = 1'b1;
        up_req_i   = 1'b0;
        up_addr_i  = 32'h0;
        up_we_i    = 1'b0;
        up_be_i    = 4'h0;
        up_wdata_i = 32'h0;
        stray_rv   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dn_req",   64'(dn_req_o),    64'(0));
        check("rst_up_rvld",  64'(up_rvalid_o), 64'(0));
        check("rst_up_err",   64'(up_err_o),    64'(0));
        check("rst_overflow", 64'(overflow_o),  64'(0));
        check("rst_busy",     64'(busy_o),      64'(0));
        check("rst_dn_fields", 64'({dn_addr_o, dn_we_o, dn_be_o}), 64'(0));
        check("rst_data",     64'({dn_wdata_o, up_rdata_o}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Single read, mmu answers 3 cycles after dn_req_o.
        fixed_delay = 3;
        issue(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);   // now cycle 1
        check("lat_req_early", 64'(dn_req_o), 64'(0));
        check("busy_queued",   64'(busy_o),   64'(1));
        @(posedge clk); #1;                                     // cycle 2
        check("lat_req_c2",    64'(dn_req_o),  64'(1));
        check("lat_req_addr",  64'(dn_addr_o), 64'(32'h0000_2100));
        repeat (3) @(posedge clk);
        #1;                                                     // cycle 5
        check("lat_rsp_early", 64'(up_rvalid_o), 64'(0));
        @(posedge clk); #1;                                     // cycle 6
        check("lat_rsp_c6",    64'(up_rvalid_o), 64'(1));
        check("lat_rsp_data",  64'(up_rdata_o),  64'(32'hDEAD_BEEF));
        check("lat_rsp_err",   64'(up_err_o),    64'(0));
        wait_resp(50);

        // Write with partial byte enables.
        fixed_delay = 4;
        issue(32'h0000_0040, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 1'b1);
        wait_resp(50);
        check("wr_overflow", 64'(overflow_o), 64'(0));

        // Four back-to-back reads, mmu data = downstream address.
        fixed_delay = 0;
        for (int i = 0; i < 4; i++)
            issue(32'(4 * i), 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        wait_resp(100);
        check("b2b_overflow", 64'(overflow_o), 64'(0));

        // Six requests with a slow mmu: one in flight, four queued, one dropped.
        repeat (3) @(posedge clk);
        #1;
        fixed_delay = 5;
        for (int i = 0; i < 6; i++)
            issue(32'h0000_0200 + 32'(4 * i), 1'b0, 4'hF, 32'h0, (i == 5), 1'b1);
        check("ovf_set", 64'(overflow_o), 64'(1));
        wait_resp(200);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_resp_count", 64'(resp_cnt), 64'(issued));
        check("ovf_sticky",     64'(overflow_o), 64'(1));
        check("ovf_idle_busy",  64'(busy_o),     64'(0));

        // Timeout: mmu ignores the request; error response TO cycles after ISSUE.
        issue(32'hF000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);   // cycle 1
        for (int c = 2; c <= 2 + 1 + int'(TO); c++) begin
            @(posedge clk); #1;
            check("to_latency", 64'(up_rvalid_o), 64'(c == 2 + 1 + int'(TO)));
        end
        repeat (2) @(posedge clk);
        #1;
        stray_rv = 1'b1;                                        // stray while idle
        @(posedge clk); #1;
        stray_rv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stray_dropped", 64'(resp_cnt), 64'(issued));

        // Randomised traffic, never more than DEPTH outstanding.
        fixed_delay = 0;
        for (int k = 0; k < 150; k++) begin
            n = 0;
            while ((issued - resp_cnt) >= int'(DEPTH) && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #0;
            r = int'($urandom_range(9, 0));
            if (r == 0)      a = {4'hF, 28'($urandom())};
            else if (r == 1) a = {4'hE, 28'($urandom())};
            else if (r == 2) a = $urandom();
            else             a = {16'h0, 16'($urandom())};
            issue(a, 1'($urandom()), 4'($urandom()), $urandom(), 1'b0, 1'b1);
        end
        wait_resp(3000);
        check("rand_overflow_sticky", 64'(overflow_o), 64'(1));

        // Reset while waiting: the transaction is abandoned silently.
        @(posedge clk); #1;
        issue(32'hF000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy_o), 64'(1));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stray_rv = 1'b1;
        @(posedge clk); #1;
        stray_rv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_busy",     64'(busy_o),      64'(0));
        check("rst_mid_overflow", 64'(overflow_o),  64'(0));
        check("rst_mid_rvalid",   64'(up_rvalid_o), 64'(0));
        check("rst_mid_count",    64'(resp_cnt),    64'(issued));

        // Bridge works normally after the abandoned transaction.
        fixed_delay = 2;
        issue(32'h0000_0300, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        wait_resp(50);
        repeat (3) @(posedge clk);
        #1;
        check("end_dn_queue", 64'(exp_dn.size()), 64'(0));
        check("end_up_queue", 64'(exp_up.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
